// File: rtl/aes192_pkg.sv
// Shared constants and types for the AES-192 inverse key schedule.
package aes192_pkg;

    localparam int NK     = 6;
    localparam int NR     = 12;
    localparam int NWORDS = 52;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_SERVE
    } state_t;

    // Rcon[1..8]; entry 7 holds Rcon[1] so the table reads in natural order.
    localparam logic [7:0][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
    };

    function automatic logic [7:0] rcon_byte(input logic [2:0] sel);
        return RCON[3'd7 - sel];
    endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word.
module sub_word
    import aes192_pkg::*;
(
    input  word_t din,
    output word_t dout
);

    // Entry 255 is S(0x00); lookups use the inverted byte as the index.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = {SBOX[~din[31:24]], SBOX[~din[23:16]],
                   SBOX[~din[15:8]],  SBOX[~din[7:0]]};

endmodule

// File: rtl/key192_inv_schedule.sv
// AES-192 key expander that streams round keys 12..0 for the inverse cipher.
module key192_inv_schedule
    import aes192_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [191:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_index,
    output logic         done
);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  phase_q, phase_d;
    logic [2:0]  rc_q, rc_d;
    logic [3:0]  rnd_q, rnd_d;
    logic        done_q, done_d;
    logic        load_en, exp_en;

    word_t       words_q [NWORDS];
    word_t       prev_w, back_w, rot_w, sub_w, temp_w, new_w;

    // phase_q tracks i mod 6, rc_q selects the next Rcon entry
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        rc_d    = rc_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        load_en = 1'b0;
        exp_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_en = 1'b1;
                    state_d = ST_EXPAND;
                    idx_d   = 6'(NK);
                    phase_d = 3'd0;
                    rc_d    = 3'd0;
                end
            end
            ST_EXPAND: begin
                exp_en  = 1'b1;
                idx_d   = idx_q + 6'd1;
                phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
                if (phase_q == 3'd0) begin
                    rc_d = rc_q + 3'd1;
                end
                if (idx_q == 6'(NWORDS - 1)) begin
                    state_d = ST_SERVE;
                    rnd_d   = 4'(NR);
                end
            end
            ST_SERVE: begin
                if (rk_ready) begin
                    if (rnd_q == 4'd0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rnd_d = rnd_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 6'd0;
            phase_q <= 3'd0;
            rc_q    <= 3'd0;
            rnd_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            rc_q    <= rc_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        prev_w = words_q[idx_q - 6'd1];
        back_w = words_q[idx_q - 6'd6];
        rot_w  = {prev_w[23:0], prev_w[31:24]};
        temp_w = (phase_q == 3'd0) ? (sub_w ^ {rcon_byte(rc_q), 24'h0}) : prev_w;
        new_w  = back_w ^ temp_w;
    end

    sub_word u_sub_word (
        .din  (rot_w),
        .dout (sub_w)
    );

    // Key storage carries no reset; contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int j = 0; j < NK; j++) begin
                words_q[j] <= key[32*(NK-1-j) +: 32];
            end
        end else if (exp_en) begin
            words_q[idx_q] <= new_w;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign rk_valid = (state_q == ST_SERVE);
    assign done     = done_q;
    assign rk_index = rk_valid ? rnd_q : 4'd0;
    assign rk_out   = rk_valid ? {words_q[{rnd_q, 2'b00}], words_q[{rnd_q, 2'b01}],
                                  words_q[{rnd_q, 2'b10}], words_q[{rnd_q, 2'b11}]}
                               : 128'd0;

endmodule

// File: tb/tb_key192_inv_schedule.sv
// Bench for key192_inv_schedule: per-cycle reference model plus FIPS-197 literal vectors.
module tb_key192_inv_schedule;

    localparam logic [191:0] KA2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [191:0] KC2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [191:0] K3  = 192'h0123456789abcdeffedcba98765432100f1e2d3c4b5a6978;
    localparam logic [191:0] K4  = 192'hdeadbeefcafebabe112233445566778899aabbccddeeff00;
    localparam logic [191:0] K5  = 192'hffffffffffffffffffffffffffffffffffffffffffffffff;
    localparam logic [191:0] K6  = 192'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da5;
    localparam logic [191:0] K7  = 192'h000000000000000000000000000000000000000000000000;
    localparam logic [191:0] K8  = 192'h8040201008040201a55a3cc30ff0f00f1357924668ace0bd;

    logic         clk = 1'b0;
    logic         rst_n, start, rk_ready;
    logic [191:0] key;
    logic         busy, rk_valid, done;
    logic [127:0] rk_out;
    logic [3:0]   rk_index;

    always #5 clk = ~clk;

    key192_inv_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key      (key),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_index (rk_index),
        .done     (done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference model: S-box built from GF(2^8) inversion and the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv = 8'h00;
        if (b != 8'h00) begin
            inv = 8'h01;
            for (int n = 0; n < 254; n++) inv = gmul(inv, b);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    logic [31:0]  m_w [52];
    logic [127:0] exp_rk [13];

    task automatic model_expand(input logic [191:0] k);
        logic [31:0] t;
        for (int j = 0; j < 6; j++) m_w[j] = k[191 - 32*j -: 32];
        for (int j = 6; j < 52; j++) begin
            t = m_w[j-1];
            if (j % 6 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {8'h01 << (j/6 - 1), 24'h0};
            end
            m_w[j] = m_w[j-6] ^ t;
        end
        for (int r = 0; r < 13; r++) exp_rk[r] = {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
    endtask

    // Cycle model: 0 idle, 1 expanding (m_cnt edges left), 2 serving round m_r.
    int   m_state = 0;
    int   m_cnt = 0;
    int   m_r = 0;
    int   hs_count = 0;
    logic m_done = 1'b0;

    always @(negedge clk) begin : cmp
        logic ev;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_valid", rk_valid, 0);
            chk("rst_out", rk_out, 0);
            chk("rst_index", rk_index, 0);
            chk("rst_done", done, 0);
            m_state = 0;
            m_done  = 1'b0;
        end else begin
            ev = (m_state == 2);
            chk("cyc_busy", busy, m_state != 0);
            chk("cyc_valid", rk_valid, ev);
            chk("cyc_done", done, m_done);
            chk("cyc_index", rk_index, ev ? m_r : 0);
            chk("cyc_out", rk_out, ev ? exp_rk[m_r] : 128'd0);
            m_done = 1'b0;
            case (m_state)
                0: if (start) begin
                    model_expand(key);
                    m_state  = 1;
                    m_cnt    = 46;
                    hs_count = 0;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_state = 2;
                        m_r     = 12;
                    end
                end
                default: if (rk_ready) begin
                    hs_count++;
                    if (m_r == 0) begin
                        m_state = 0;
                        m_done  = 1'b1;
                    end else begin
                        m_r--;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [191:0] k);
        start = 1'b1;
        key   = k;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!rk_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk(nm, done, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int n;
        logic [127:0] hold_out;
        logic [3:0]   hold_idx;

        rst_n = 1'b0; start = 1'b0; key = '0; rk_ready = 1'b0;

        model_expand(KA2);
        chk("model_a2_w6", m_w[6], 32'hfe0c91f7);
        chk("model_a2_rk12", exp_rk[12], 128'he98ba06f448c773c8ecc720401002202);
        model_expand(KC2);
        chk("model_c2_rk12", exp_rk[12], 128'ha4970a331a78dc09c418c271e3a41d5d);
        chk("model_c2_rk0", exp_rk[0], 128'h000102030405060708090a0b0c0d0e0f);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_valid", rk_valid, 0);
        chk("reset_out", rk_out, 0);
        chk("reset_index", rk_index, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;
        tick();

        rk_ready = 1'b1;
        do_start(KA2);
        chk("a2_busy_after_start", busy, 1);
        wait_valid(cyc);
        chk("a2_latency", cyc, 46);
        chk("a2_first_out", rk_out, 128'he98ba06f448c773c8ecc720401002202);
        chk("a2_first_index", rk_index, 12);
        wait_done("a2_done");
        chk("a2_busy_at_done", busy, 0);
        tick();

        do_start(KC2);
        wait_valid(cyc);
        chk("c2_latency", cyc, 46);
        chk("c2_first_out", rk_out, 128'ha4970a331a78dc09c418c271e3a41d5d);
        chk("c2_first_index", rk_index, 12);
        n = 0;
        while (!(rk_valid && rk_index == 4'd0) && n < 100) begin
            tick();
            n++;
        end
        chk("c2_last_out", rk_out, 128'h000102030405060708090a0b0c0d0e0f);
        chk("c2_last_index", rk_index, 0);
        tick();
        chk("c2_done_pulse", done, 1);
        chk("c2_busy_low", busy, 0);
        tick();
        chk("c2_done_single", done, 0);
        chk("c2_handshakes", hs_count, 13);

        do_start(K3);
        repeat (10) tick();
        do_start(K4);
        n = 0;
        while (!(rk_valid && rk_index == 4'd7) && n < 100) begin
            tick();
            n++;
        end
        chk("bp_reached_r7", rk_index, 7);
        rk_ready = 1'b0;
        hold_out = rk_out;
        hold_idx = rk_index;
        start = 1'b1;
        key   = K4;
        for (int s = 0; s < 5; s++) begin
            tick();
            start = 1'b0;
            chk("bp_stall_out", rk_out, hold_out);
            chk("bp_stall_index", rk_index, hold_idx);
        end
        n = 0;
        while (!done && n < 100) begin
            rk_ready = ~rk_ready;
            tick();
            n++;
        end
        chk("bp_done", done, 1);
        chk("bp_handshakes", hs_count, 13);
        rk_ready = 1'b1;
        tick();

        do_start(K5);
        repeat (24) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", rk_valid, 0);
        chk("mid_rst_out", rk_out, 0);
        chk("mid_rst_index", rk_index, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        do_start(K6);
        wait_valid(cyc);
        chk("post_rst_latency", cyc, 46);
        wait_done("post_rst_done");
        chk("post_rst_handshakes", hs_count, 13);

        do_start(K7);
        wait_done("b2b_first_done");
        do_start(K8);
        chk("b2b_busy", busy, 1);
        wait_valid(cyc);
        chk("b2b_latency", cyc, 46);
        wait_done("b2b_second_done");
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key192_inv_schedule.md
# key192_inv_schedule

Iterative AES-192 key expander for the decryption datapath. Accepts a 192-bit cipher key, expands it into all 52 schedule words one word per cycle, then streams the 13 round keys in reverse order (round 12 down to round 0) over a valid/ready handshake. The consumer is the AddRoundKey stage ahead of the inverse MixColumns stage in the decrypt round. This block uses the straightforward inverse cipher, so round keys are delivered untransformed, with no InvMixColumns applied to keys.

## Interface
- No parameters; all sizes are fixed by AES-192.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  load `key` and begin expansion; honoured only in IDLE
- key  input  192  cipher key; key[191:160] is w0 and key[31:0] is w5
- busy  output  1  high in EXPAND and SERVE
- rk_valid  output  1  round key presented on `rk_out`
- rk_ready  input  1  consumer accepts `rk_out` when high together with `rk_valid`
- rk_out  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96] (column 0 at the MSB)
- rk_index  output  4  round number r of the key on `rk_out` (12..0)
- done  output  1  one-cycle pulse after the round-0 key is accepted

## Operation
- **FSM states:** IDLE, EXPAND, SERVE.
- **IDLE:**
  - On `start`, write key words w0..w5 into the word array.
  - Set word counter i=6 and go to EXPAND.
- **EXPAND:** each cycle, compute and write w[i], then increment i.
  - temp = w[i-1].
  - If i mod 6 == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/6], 24'h0}.
  - w[i] = w[i-6] ^ temp.
  - Rcon[1..8] = 01, 02, 04, 08, 10, 20, 40, 80.
  - RotWord rotates bytes left by one: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
  - After w51 is written, set r=12 and go to SERVE.
- **SERVE:**
  - `rk_valid`=1; `rk_out` is the round-r words; `rk_index`=r.
  - On `rk_valid` & `rk_ready`: if r>0, decrement r; if r==0, go to IDLE and pulse `done` on the next cycle.
- **Ignored inputs:** `start` is ignored in EXPAND and SERVE; `key` is sampled only on the accepting cycle.
- **Stall:** `rk_out` and `rk_index` hold stable while `rk_valid` & !`rk_ready`.
- **Reset:** asserting `rst_n` low at any point returns the FSM to IDLE immediately; a partially served or expanded schedule is discarded.
- **Output gating:** `rk_out` and `rk_index` read 0 whenever `rk_valid`=0.

## Timing
- **Reset values:** `busy`=0, `rk_valid`=0, `rk_out`=0, `rk_index`=0, `done`=0; FSM in IDLE; counters 0. The word array need not be reset.
- **Accept edge E0:** `start` is sampled high in IDLE at edge E0. `busy` is high after E0.
- **Expansion:** w6..w51 are written at edges E1..E46.
- **First key:** `rk_valid` rises after E46, a start-to-first-key latency of 46 cycles.
- **Key rate:** one round key per cycle when `rk_ready` is held high. The full drain takes 13 cycles.
- **Completion:** `done` is high for exactly the one cycle following the round-0 handshake edge. `busy` falls on that same edge.
- **Back-to-back runs:** `start` asserted in the cycle `done` is high is accepted, since the FSM is already in IDLE.
- **No combinational paths:** `rk_valid` has no combinational dependency on `rk_ready`, and `rk_out` has none on `start`.

## Structure
- **Package `aes192_pkg`:**
  - Constants NK=6, NR=12, NWORDS=52.
  - Rcon table (8 x 8 bit).
  - FSM state enum.
  - 32-bit word typedef.
- **Sub-module `sub_word`:** combinational, four byte S-box lookups on a 32-bit word. It is instanced once, on the RotWord output.
- **Word storage:** a 52 x 32 register array, written at index i and read at 4r..4r+3.

## Test plan
- **FIPS-197 A.2 key, first and last words:** key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - Internal w6 = fe0c91f7.
  - First `rk_out` = e98ba06f448c773c8ecc720401002202 with `rk_index`=12, exactly 46 cycles after the start edge.
- **FIPS-197 C.2 key, full drain:** key 000102...1617, `rk_ready`=1.
  - First key = a4970a331a78dc09c418c271e3a41d5d with `rk_index`=12.
  - Last key = 000102030405060708090a0b0c0d0e0f with `rk_index`=0.
  - `done` pulses once, and `busy` is low afterwards.
- **Backpressure:** hold `rk_ready` low for 5 cycles at r=7, then toggle it every cycle.
  - `rk_out` and `rk_index` are stable while stalled.
  - No key is skipped or duplicated; 13 handshakes in total.
- **Ignored start:** pulse `start` with a different key during EXPAND and again during SERVE. The output stream is unchanged.
- **Reset mid-operation:** assert `rst_n` low at i=30.
  - All outputs return to 0 asynchronously.
  - A new `start` after release yields the correct schedule for the new key.
- **Back-to-back:** assert `start` during the `done` cycle. The second run's first key appears 46 cycles later.
